// File: rtl/shortcut_fork_16_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shortcut_fork_16_if : source, layer-path and shortcut-path signals of
//                       shortcut_fork_16 (slave = fork, master = environment)
// Revision: 1.0
// ---------------------------------------------------------------------------
interface shortcut_fork_16_if #(
   parameter int LANES      = 16,
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
   logic                       in_valid;
   logic                       in_ready;
   logic [LANES-1:0][DW-1:0]   d_in;
   logic                       layer_valid;
   logic [LANES-1:0][DW-1:0]   d_out_layer;
   logic                       short_cut_valid;
   logic [LANES-1:0][DW-1:0]   d_out_short_cut;
   logic                       layer_done;
   logic [CNT_W-1:0]           occupancy;
   logic                       o_sof;
   logic                       o_eof;
   logic                       err_underflow;

   modport master (
      output in_valid, d_in, layer_done,
      input  in_ready, layer_valid, d_out_layer, short_cut_valid,
             d_out_short_cut, occupancy, o_sof, o_eof, err_underflow
   );

   modport slave (
      input  in_valid, d_in, layer_done,
      output in_ready, layer_valid, d_out_layer, short_cut_valid,
             d_out_short_cut, occupancy, o_sof, o_eof, err_underflow
   );
endinterface
`default_nettype wire

// File: rtl/shortcut_fork_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shortcut_fork_16 : forks a 16-lane fp32 stream to the layer path and the
//                    residual shortcut FIFOs with credit throttling and SOF/EOF.
// Option macro: SHORTCUT_FORK_FRAME_DRAIN_EN (block next frame until drained)
// Revision: 1.0
// ---------------------------------------------------------------------------
module shortcut_fork_16 #(
   parameter int LANES      = 16,
   parameter int DW         = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int FRAME_LEN  = 1024,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  wire logic            clk,
   input  wire logic            rst,
   shortcut_fork_16_if.slave    bus
);

   localparam int               BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(FIFO_DEPTH);

`ifdef SHORTCUT_FORK_FRAME_DRAIN_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DRAIN = 2'd2} state_t;
   localparam state_t S_AFTER_EOF = S_DRAIN;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1} state_t;
   localparam state_t S_AFTER_EOF = S_IDLE;
`endif

   state_t                    state_q, state_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic [CNT_W-1:0]          occ_q, occ_d;
   logic                      err_q, err_d;
   logic                      sof_q, sof_d;
   logic                      eof_q, eof_d;
   logic                      valid_q;
   logic [LANES-1:0][DW-1:0]  data_q;
   logic                      w_drain;
   logic                      w_ready;
   logic                      w_accept;

`ifdef SHORTCUT_FORK_FRAME_DRAIN_EN
   assign w_drain = (state_q == S_DRAIN);
`else
   assign w_drain = 1'b0;
`endif

   // Ready depends only on registered state, never on layer_done.
   assign w_ready  = !rst && !w_drain && (occ_q < DEPTH);
   assign w_accept = bus.in_valid && w_ready;

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               sof_d = 1'b1;
               if (LAST_BEAT == '0) begin
                  eof_d   = 1'b1;
                  beat_d  = '0;
                  state_d = S_AFTER_EOF;
               end else begin
                  beat_d  = BEAT_W'(1);
                  state_d = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            if (w_accept) begin
               if (beat_q == LAST_BEAT) begin
                  eof_d   = 1'b1;
                  beat_d  = '0;
                  state_d = S_AFTER_EOF;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
               end
            end
         end
`ifdef SHORTCUT_FORK_FRAME_DRAIN_EN
         S_DRAIN: begin
            if (occ_q == '0) begin
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Credit is taken at accept; a pop with nothing outstanding is an error.
   always_comb begin
      occ_d = occ_q;
      err_d = err_q;
      if (w_accept && !bus.layer_done) begin
         occ_d = occ_q + CNT_W'(1);
      end else if (!w_accept && bus.layer_done) begin
         if (occ_q == '0) begin
            err_d = 1'b1;
         end else begin
            occ_d = occ_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         occ_q   <= '0;
         err_q   <= 1'b0;
         sof_q   <= 1'b0;
         eof_q   <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         occ_q   <= occ_d;
         err_q   <= err_d;
         sof_q   <= sof_d;
         eof_q   <= eof_d;
         valid_q <= w_accept;
         if (w_accept) begin
            data_q <= bus.d_in;
         end
      end
   end

   assign bus.in_ready        = w_ready;
   assign bus.layer_valid     = valid_q;
   assign bus.short_cut_valid = valid_q;
   assign bus.d_out_layer     = data_q;
   assign bus.d_out_short_cut = data_q;
   assign bus.occupancy       = occ_q;
   assign bus.o_sof           = sof_q;
   assign bus.o_eof           = eof_q;
   assign bus.err_underflow   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shortcut_fork_16.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_shortcut_fork_16 : directed + random bench for shortcut_fork_16 against
//                       a beat/credit-level reference model (FRAME_LEN=4).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_shortcut_fork_16;
   localparam int LANES = 16;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int FL    = 4;
   localparam int CW    = $clog2(DEPTH + 1);
`ifdef SHORTCUT_FORK_FRAME_DRAIN_EN
   localparam bit DRAIN_EN = 1'b1;
`else
   localparam bit DRAIN_EN = 1'b0;
`endif

   typedef logic [LANES-1:0][DW-1:0] beat_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   shortcut_fork_16_if #(.LANES(LANES), .DW(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) bus ();

   shortcut_fork_16 #(
      .LANES(LANES), .DW(DW), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .CNT_W(CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: outstanding credits, position within frame, drain flag.
   int    m_occ;
   int    m_beat;
   bit    m_err;
   bit    m_drain;
   bit    m_valid;
   bit    m_sof;
   bit    m_eof;
   beat_t m_data;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_occ = 0; m_beat = 0; m_err = 0; m_drain = 0;
      m_valid = 0; m_sof = 0; m_eof = 0; m_data = '0;
   endtask

   function automatic bit m_ready();
      return !m_drain && (m_occ < DEPTH);
   endfunction

   function automatic beat_t base_beat();
      beat_t b;
      for (int k = 0; k < LANES; k++) b[k] = 32'h3F80_0000 + k;
      return b;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      for (int k = 0; k < LANES; k++) b[k] = $urandom;
      return b;
   endfunction

   task automatic check_outputs(input string ctx);
      chk({ctx, ".layer_valid"}, bus.layer_valid, m_valid);
      chk({ctx, ".sc_valid"},    bus.short_cut_valid, m_valid);
      chk({ctx, ".d_layer"},     bus.d_out_layer, m_data);
      chk({ctx, ".d_sc"},        bus.d_out_short_cut, m_data);
      chk({ctx, ".sof"},         bus.o_sof, m_sof);
      chk({ctx, ".eof"},         bus.o_eof, m_eof);
      chk({ctx, ".occ"},         bus.occupancy, m_occ);
      chk({ctx, ".err"},         bus.err_underflow, m_err);
   endtask

   // One clock: drive at negedge, check ready, model the edge, check outputs.
   task automatic step(input string ctx, input bit v, input bit done, input beat_t d);
      bit rdy, acc;
      bus.in_valid   = v;
      bus.layer_done = done;
      bus.d_in       = d;
      #1;
      rdy = m_ready();
      chk({ctx, ".in_ready"}, bus.in_ready, rdy);
      acc = v && rdy;
      @(posedge clk);
      m_valid = acc;
      m_sof   = 0;
      m_eof   = 0;
      if (acc) begin
         m_data = d;
         m_sof  = (m_beat == 0);
         m_eof  = (m_beat == FL - 1);
         m_beat = (m_beat + 1) % FL;
      end
      if (m_drain) m_drain = (m_occ != 0);
      else         m_drain = DRAIN_EN && acc && m_eof;
      if (acc && !done) m_occ++;
      else if (!acc && done) begin
         if (m_occ == 0) m_err = 1;
         else            m_occ--;
      end
      @(negedge clk);
      check_outputs(ctx);
   endtask

   task automatic do_reset(input string ctx);
      bus.in_valid   = 1'b1;
      bus.layer_done = 1'b0;
      bus.d_in       = rand_beat();
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs({ctx, ".async"});
      chk({ctx, ".in_ready_rst"}, bus.in_ready, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_outputs({ctx, ".held"});
      chk({ctx, ".in_ready_held"}, bus.in_ready, 1'b0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      chk({ctx, ".in_ready_post"}, bus.in_ready, 1'b1);
      chk({ctx, ".occ_post"}, bus.occupancy, 0);
   endtask

   initial begin
      int  sent;
      bit  v, dn;
      bus.in_valid   = 1'b0;
      bus.layer_done = 1'b0;
      bus.d_in       = '0;
      #2;
      do_reset("reset");

      step("single", 1'b1, 1'b0, base_beat());
      chk("single.sof_directed", bus.o_sof, 1'b1);

      for (int i = 1; i < DEPTH; i++) step("fill", 1'b1, 1'b0, rand_beat());
      chk("stall.occ_full", bus.occupancy, DEPTH);
      step("stall", 1'b1, 1'b0, rand_beat());
      chk("stall.in_ready_low", bus.in_ready, 1'b0);
      step("pop1", 1'b0, 1'b1, rand_beat());
      chk("pop1.occ7", bus.occupancy, DEPTH - 1);
      step("simul", 1'b1, 1'b1, rand_beat());
      for (int i = 0; i < 20 && m_occ > 0; i++) step("empty", 1'b0, 1'b1, rand_beat());

      do_reset("frame_rst");
      sent = 0;
      for (int i = 0; i < 60 && (sent < 8 || m_occ > 0); i++) begin
         v  = (sent < 8);
         dn = (i >= 3) && (m_occ > 0);
         if (v && m_ready()) sent++;
         step("frame", v, dn, rand_beat());
      end

      step("underflow", 1'b0, 1'b1, rand_beat());
      chk("underflow.err_directed", bus.err_underflow, 1'b1);
      step("underflow_hold", 1'b0, 1'b0, rand_beat());

      for (int i = 0; i < 300; i++) begin
         v  = 1'($urandom_range(0, 1));
         dn = (m_occ > 0) && ($urandom_range(0, 2) != 0);
         step("random", v, dn, rand_beat());
      end

      do_reset("clear_rst");
      for (int i = 0; i < 3; i++) step("mid", 1'b1, 1'b0, rand_beat());
      do_reset("mid_rst");
      step("after_mid", 1'b1, 1'b0, rand_beat());
      chk("after_mid.sof_directed", bus.o_sof, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/shortcut_fork_16.md
# shortcut_fork_16

Splits one 16-lane fp32 feature stream into two identical streams: one feeding the layer (convolution) path, and one feeding the shortcut FIFOs of the residual adder. Tracks how many shortcut beats are written but not yet consumed, and throttles the source so those FIFOs can never overflow. Also delimits frames with start-of-frame and end-of-frame markers. Sits at the head of every residual block, upstream of both the layer chain and the residual adder.

## Interface
- `LANES`, 16, number of parallel lanes.
- `DW`, 32, lane width in bits (fp32, passed through unmodified).
- `FIFO_DEPTH`, 8, depth of each downstream shortcut FIFO (credit limit).
- `FRAME_LEN`, 1024, beats per frame.
- `CNT_W`, `$clog2(FIFO_DEPTH+1)`, width of the occupancy counter.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: source beat valid.
- `in_ready`, out, 1: block accepts a beat this cycle.
- `d_in[LANES-1:0]`, in, DW each: source data.
- `layer_valid`, out, 1: beat valid to the layer path.
- `d_out_layer[LANES-1:0]`, out, DW each: layer-path data.
- `short_cut_valid`, out, 1: write enable for the shortcut FIFOs.
- `d_out_short_cut[LANES-1:0]`, out, DW each: shortcut data.
- `layer_done`, in, 1: one pulse per beat popped from the shortcut FIFOs. Wired to the adder's layer-valid input.
- `occupancy`, out, CNT_W: shortcut beats written and not yet consumed.
- `o_sof`, out, 1: qualifies the first beat of a frame (aligned with the output valids).
- `o_eof`, out, 1: qualifies the last beat of a frame (aligned with the output valids).
- `err_underflow`, out, 1: sticky; set when `layer_done` arrives while `occupancy` is 0.

## Operation
- **Accept:** `accept = in_valid & in_ready`.
- **Ready:** `in_ready = !rst & (state != DRAIN) & (occupancy < FIFO_DEPTH)`.
  - Purely registered terms; no combinational path from `layer_done`.
- **Output register:** on accept, `d_in` is registered into both `d_out_layer` and `d_out_short_cut`.
  - `layer_valid` and `short_cut_valid` pulse together for one cycle.
  - With no accept, both valids are 0 and the data registers hold.
- **Occupancy:** `occupancy <= occupancy + accept - layer_done`.
  - Credit is reserved at accept, so the count never exceeds `FIFO_DEPTH`.
  - Accept and `layer_done` in the same cycle leave it unchanged.
  - `layer_done` with `occupancy == 0` (and no accept): hold at 0 and set `err_underflow`. It clears only on reset.
- **Beat counter:** counts 0..FRAME_LEN-1 and wraps to 0 after the last beat.
- **State machine:**
  - IDLE: first accept -> STREAM, `beat_cnt <= 1`; `o_sof` is asserted with that beat's output.
  - STREAM: each accept increments `beat_cnt`. The accept at `beat_cnt == FRAME_LEN-1` asserts `o_eof` with that output and clears the counter.
    - `FRAME_LEN == 1`: `o_sof` and `o_eof` are both asserted on the single beat.
  - DRAIN (exists only with the macro defined): no accepts. Move to IDLE in the cycle after `occupancy` reads 0.
- **Reset:** asynchronous, allowed at any time, including mid-frame. It sets:
  - state = IDLE, counters = 0
  - all outputs = 0, including data, valids, `o_sof`, `o_eof`, `occupancy`, `err_underflow`, and `in_ready`
  - in-flight beats are discarded.

## Timing
- Latency from `d_in` to both outputs: 1 cycle.
- Throughput: 1 beat/cycle while `occupancy < FIFO_DEPTH`.
- `occupancy` updates in the cycle after accept or `layer_done`; `in_ready` follows combinationally from the registered count.
- With `occupancy == FIFO_DEPTH` and a `layer_done` pulse at cycle t: `in_ready` rises at cycle t+1.

## Configuration
- Macro: `SHORTCUT_FORK_FRAME_DRAIN_EN`.
- Defined: after the EOF beat, the FSM enters DRAIN. The next frame is blocked until every shortcut beat of the current frame has been consumed. This guarantees frames are isolated in the adder FIFOs.
- Undefined: no DRAIN state. The EOF accept moves the FSM straight to IDLE, and the next frame may begin the following cycle, limited only by credit.

## Test plan
Common settings: `FIFO_DEPTH=8`, `FRAME_LEN=4`.
- **Reset:** `in_valid=1` held through reset -> all outputs 0, `in_ready=0`. The first cycle after deassert gives `in_ready=1`, `occupancy=0`.
- **Single beat:** lane k = `32'h3F80_0000+k` -> one cycle later both valids are 1, both data outputs match, `o_sof=1`, `occupancy=1`.
- **Credit stall:** 8 beats with `layer_done=0`.
  - Required: `in_ready=0` once `occupancy=8`.
  - One `layer_done` pulse -> `occupancy=7` and `in_ready=1` the next cycle.
  - Simultaneous accept and `layer_done` -> `occupancy` unchanged.
- **Frame markers:** 8 back-to-back beats with `layer_done` following 3 cycles behind -> `o_sof` on beats 0 and 4, `o_eof` on beats 3 and 7.
  - Macro defined: `in_ready=0` after beat 3 until `occupancy` reaches 0.
- **Underflow:** `layer_done` with `occupancy=0` -> `err_underflow=1` and held, `occupancy=0`; the bit clears only on `rst`.
- **Mid-frame reset:** assert `rst` after beat 2 -> outputs and counters return to 0. The next accepted beat carries `o_sof`.
